// File: rtl/cd_pkg.sv
// Shared constants, state type and the single-bit CRC update for the
// bit-serial MODBUS CRC-16 frame checker.
package cd_pkg;

    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY      = 16'hA001;
    localparam logic [15:0] CRC_RESIDUE   = 16'h0000;
    localparam int          MIN_FRAME_LEN = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } chk_state_t;

    // One reflected CRC step: feed a single data bit, LSB-first ordering.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
        logic [15:0] shifted;
        shifted = {1'b0, crc[15:1]};
        if (crc[0] ^ din) begin
            crc_step = shifted ^ CRC_POLY;
        end else begin
            crc_step = shifted;
        end
    endfunction

endpackage

// File: rtl/cd_crc.sv
// Bit-serial CRC-16 register: reloads on clean, advances one bit per data_clk.
module cd_crc
    import cd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clean,
    input  logic        data_clk,
    input  logic        data_in,
    output logic [15:0] crc_out
);

    logic [15:0] r_crc;

    // CRC register: reload has priority over a shift strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crc <= CRC_INIT;
        end else if (clean) begin
            r_crc <= CRC_INIT;
        end else if (data_clk) begin
            r_crc <= crc_step(r_crc, data_in);
        end else begin
            r_crc <= r_crc;
        end
    end

    assign crc_out = r_crc;

endmodule

// File: rtl/cd_crc_chk.sv
// MODBUS CRC-16 frame checker: accepts one byte per 9 cycles, shifts it
// LSB-first into cd_crc and reports a registered verdict at end of frame.
module cd_crc_chk
    import cd_pkg::*;
#(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clean,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             done,
    output logic             crc_ok,
    output logic [LEN_W-1:0] frame_len,
    output logic [15:0]      crc_val
);

    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_FRAME_LEN);

    chk_state_t       r_state;
    logic [2:0]       r_cnt;
    logic [7:0]       r_byte;
    logic             r_last;
    logic             r_rdy;
    logic             r_done;
    logic             r_ok;
    logic             r_ovf;
    logic             r_end;
    logic [LEN_W-1:0] r_len;

    logic             w_hs;
    logic             w_shift;
    logic             w_bit;
    logic             w_reload;
    logic [15:0]      w_crc;
    logic [15:0]      w_crc_next;

    assign in_ready   = r_rdy & ~clean;
    assign w_hs       = in_valid & in_ready;
    assign w_shift    = (r_state == ST_SHIFT);
    assign w_bit      = r_byte[r_cnt];
    // A new frame reloads the CRC only once the previous verdict was given.
    assign w_reload   = clean | (w_hs & r_end);
    assign w_crc_next = crc_step(w_crc, w_bit);

    cd_crc u_crc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clean    (w_reload),
        .data_clk (w_shift),
        .data_in  (w_bit),
        .crc_out  (w_crc)
    );

    // Byte handshake, shift sequencing, length counting and verdict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_byte  <= 8'h00;
            r_last  <= 1'b0;
            r_rdy   <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_ovf   <= 1'b0;
            r_end   <= 1'b0;
            r_len   <= LEN_ZERO;
        end else if (clean) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_rdy   <= 1'b1;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_ovf   <= 1'b0;
            r_end   <= 1'b0;
            r_len   <= LEN_ZERO;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_state <= ST_SHIFT;
                        r_rdy   <= 1'b0;
                        r_cnt   <= 3'd0;
                        r_byte  <= in_data;
                        r_last  <= in_last;
                        r_end   <= 1'b0;
                        if (r_end) begin
                            r_len <= LEN_ONE;
                            r_ovf <= 1'b0;
                            r_ok  <= 1'b0;
                        end else if (r_len == LEN_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_len <= r_len + LEN_ONE;
                        end
                    end else begin
                        r_rdy <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_IDLE;
                        r_rdy   <= 1'b1;
                        r_cnt   <= 3'd0;
                        if (r_last) begin
                            r_done <= 1'b1;
                            r_end  <= 1'b1;
                            r_ok   <= (w_crc_next == CRC_RESIDUE) &&
                                      (r_len >= LEN_MIN) && !r_ovf;
                        end else begin
                            r_end <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 3'd0;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign crc_ok    = r_ok;
    assign frame_len = r_len;
    assign crc_val   = w_crc;

endmodule

// File: doc/cd_crc_chk.md
CD_CRC_CHK -- requirements
Module: cd_crc_chk

Interface
REQ-001 SHALL have parameter LEN_W, default 10, width of the frame byte counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clean  input  1  synchronous abort: discards the current frame and re-initialises the checker.
REQ-005 SHALL have port in_valid  input  1  marks in_data as a valid byte.
REQ-006 SHALL have port in_data  input  8  frame byte, including the two trailing CRC bytes, low CRC byte first.
REQ-007 SHALL have port in_last  input  1  marks the final byte of the frame; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  checker can accept a byte this cycle.
REQ-009 SHALL have port done  output  1  single-cycle pulse when the frame verdict is available.
REQ-010 SHALL have port crc_ok  output  1  verdict for the frame; valid while done=1 and held until the next frame starts.
REQ-011 SHALL have port frame_len  output  LEN_W  bytes accepted in the frame, CRC bytes included; held with crc_ok.
REQ-012 SHALL have port crc_val  output  16  running CRC register; zero after a good frame.

Function
REQ-013 SHALL compute MODBUS CRC-16 (reflected polynomial 0xA001, init 0xFFFF, LSB first), one bit per clk.
REQ-014 SHALL implement states IDLE and SHIFT; IDLE→SHIFT on handshake (in_valid & in_ready); SHIFT→IDLE after exactly 8 bit cycles.
REQ-015 SHALL drive in_ready=1 only in IDLE with clean=0; one byte therefore takes 9 cycles: 1 accept cycle plus 8 shift cycles.
REQ-016 SHALL latch in_data and in_last on handshake and shift bit k (k=0..7, LSB first) in shift cycle k.
REQ-017 SHALL increment frame_len on each handshake; the counter saturates at 2^LEN_W-1 and sets an internal overflow flag.
REQ-018 SHALL pulse done in the cycle after the 8th shift cycle of a byte accepted with in_last=1.
REQ-019 SHALL set crc_ok=1 only if crc_val==0x0000, frame_len>=3 and there was no overflow; otherwise crc_ok=0.
REQ-020 SHALL reload the CRC to 0xFFFF, clear frame_len, crc_ok and the overflow flag on the first handshake after done.
REQ-021 SHALL ignore in_data and in_last while in_ready=0; no byte is lost or duplicated.
REQ-022 SHALL, when clean=1 in any state, return to IDLE, reload the CRC to 0xFFFF, clear frame_len, crc_ok and the overflow flag, and suppress done in that cycle; clean takes priority over a handshake.
REQ-023 SHALL treat a single-byte frame (in_last on the first byte) as a completed frame: done pulses with crc_ok=0.

Reset
REQ-024 SHALL, while reset_n=0, enter IDLE, set the CRC to 0xFFFF and drive in_ready=0, done=0, crc_ok=0, frame_len=0, crc_val=0xFFFF.
REQ-025 SHALL drive in_ready=1 in the first clock after reset_n deasserts; a reset mid-frame discards the frame with no done.

Structure
REQ-026 SHALL take CRC_INIT=16'hFFFF, CRC_POLY=16'hA001, CRC_RESIDUE=16'h0000 and MIN_FRAME_LEN=3 from a shared cd_pkg package.
REQ-027 SHALL instantiate one cd_crc bit-serial sub-module, driving clean = reload condition, data_clk = shift-cycle strobe and data_in = current bit, and reading crc_out as crc_val.
REQ-028 SHALL keep the shift counter (3 bits), the byte latch and the verdict logic in cd_crc_chk itself.

Verification
REQ-029 Bench SHALL send bytes 01 03 00 00 00 01 84 0A (in_last on 0A) -> done pulse, crc_ok=1, frame_len=8, crc_val=0x0000.
REQ-030 Bench SHALL send the same frame with the final byte 0B -> done pulse, crc_ok=0, frame_len=8, crc_val!=0.
REQ-031 Bench SHALL send ASCII "123456789" then 37 4B -> crc_ok=1, frame_len=11; sampling crc_val before 37 is sent gives 0x4B37.
REQ-032 Bench SHALL hold in_valid=1 continuously -> exactly one handshake per 9 cycles, and done occurs 9 cycles after the handshake of the last byte.
REQ-033 Bench SHALL assert clean in the 4th shift cycle of byte 3, then send a good 8-byte frame -> no done for the aborted frame; the good frame gives crc_ok=1 and frame_len=8.
REQ-034 Bench SHALL send a 1-byte frame, then, with LEN_W=3, a 9-byte frame -> both give done with crc_ok=0; the second gives frame_len=7 (saturated).
